// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Queued note player sitting between the CPU IO bus and the tonegen
//   register interface. The CPU pushes {period[31:16], duration[15:0]} words
//   into a small FIFO. The sequencer then issues the tonegen period and
//   duration writes one note at a time, and waits for each tone to finish
//   before it sends the next one.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   read, write         : CPU bus strobes
//   queue_cs            : note queue register (write pushes data_in)
//   status_cs           : status register (read; also clears overflow)
//   control_cs          : control register (bit0 paused, bit1 flush)
//   data_in             : CPU write data
//   data_out            : CPU read data, 0 unless data_out_valid
//   data_out_valid      : read & status_cs
//   tone_write          : tonegen write strobe
//   tone_period_cs      : tonegen period register select
//   tone_duration_cs    : tonegen duration register select
//   tone_data           : tonegen write data
//   tone_busy           : tonegen playing flag
module tone_sequencer #(
  parameter int DEPTH          = 8,
  parameter int PERIOD_WIDTH   = 16,
  parameter int DURATION_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        queue_cs,
  input  logic        status_cs,
  input  logic        control_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        tone_write,
  output logic        tone_period_cs,
  output logic        tone_duration_cs,
  output logic [31:0] tone_data,
  input  logic        tone_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PERIOD,
    ST_WR_DURATION,
    ST_WAIT_START,
    ST_WAIT_END
  } state_t;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic queue_wr;
  logic control_wr;
  logic status_rd;
  logic flush;

  assign queue_wr   = write & queue_cs;
  assign control_wr = write & control_cs;
  assign status_rd  = read & status_cs;
  assign flush      = control_wr & data_in[1];

  // ---------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------
  logic [31:0]      mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             paused_reg, paused_next;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push_ok;
  logic             push_drop;
  logic             pop_req;
  logic             pop_ok;
  logic [DEPTH-1:0] entry_we;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(DEPTH));

  // Full is judged on the pre-edge count, so a pop in the same cycle does
  // not make room for the push. Flush overrides any push.
  assign push_ok   = queue_wr & ~fifo_full & ~flush;
  assign push_drop = queue_wr & fifo_full;
  assign pop_ok    = pop_req & ~fifo_empty & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem_reg[i] <= data_in;
      end
    end
  end

  // Head word is read combinationally so IDLE can inspect it in the very
  // cycle after the push lands.
  logic [31:0]               head_word;
  logic [PERIOD_WIDTH-1:0]   head_period;
  logic [DURATION_WIDTH-1:0] head_duration;

  assign head_word     = mem_reg[rd_ptr_reg];
  assign head_period   = head_word[16 +: PERIOD_WIDTH];
  assign head_duration = head_word[DURATION_WIDTH-1:0];

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    paused_next   = paused_reg;
    // A status read clears overflow, but a same-cycle overflow re-sets it.
    overflow_next = (overflow_reg & ~status_rd) | push_drop;

    if (control_wr) begin
      paused_next = data_in[0];
    end

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_next = count_reg + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_next = count_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      paused_reg   <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      paused_reg   <= paused_next;
    end
  end

  // ---------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------
  state_t                    state_reg, state_next;
  logic [1:0]                timer_reg, timer_next;
  logic                      latch_head;
  logic [PERIOD_WIDTH-1:0]   note_period_reg;
  logic [DURATION_WIDTH-1:0] note_duration_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      timer_reg         <= '0;
      note_period_reg   <= '0;
      note_duration_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      // The note is captured on leaving IDLE so a later flush cannot
      // corrupt the writes already under way.
      if (latch_head) begin
        note_period_reg   <= head_period;
        note_duration_reg <= head_duration;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop_req    = 1'b0;
    latch_head = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // A note flushed in this cycle must not be dispatched.
        if (!fifo_empty && !paused_reg && !tone_busy && !flush) begin
          if (head_duration == '0) begin
            pop_req = 1'b1;
          end else begin
            latch_head = 1'b1;
            state_next = ST_WR_PERIOD;
          end
        end
      end
      ST_WR_PERIOD: begin
        state_next = ST_WR_DURATION;
      end
      ST_WR_DURATION: begin
        pop_req    = 1'b1;
        timer_next = '0;
        state_next = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // Give up after four idle cycles so a silent tonegen cannot stall
        // the queue forever.
        if (tone_busy) begin
          state_next = ST_WAIT_END;
        end else if (timer_reg == 2'd3) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg + 2'd1;
        end
      end
      ST_WAIT_END: begin
        if (!tone_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tone_write       = 1'b0;
    tone_period_cs   = 1'b0;
    tone_duration_cs = 1'b0;
    tone_data        = '0;
    case (state_reg)
      ST_WR_PERIOD: begin
        tone_write     = 1'b1;
        tone_period_cs = 1'b1;
        tone_data      = 32'(note_period_reg);
      end
      ST_WR_DURATION: begin
        tone_write       = 1'b1;
        tone_duration_cs = 1'b1;
        tone_data        = 32'(note_duration_reg);
      end
      default: begin
        tone_write = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Status read path
  // ---------------------------------------------------------------------
  logic        seq_busy;
  logic [31:0] status_word;

  assign seq_busy    = (state_reg != ST_IDLE) | tone_busy;
  assign status_word = {16'h0000, 8'(count_reg), 3'b000,
                        paused_reg, overflow_reg, seq_busy,
                        fifo_full, fifo_empty};

  assign data_out_valid = status_rd;
  assign data_out       = status_rd ? status_word : 32'h0000_0000;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer. A stub tonegen raises tone_busy for 16
// cycles after each duration write (mode 1) or never (mode 0). A monitor
// logs every tonegen write with the clock-edge index at which it was seen.
module tb_tone_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        queue_cs = 1'b0;
  logic        status_cs = 1'b0;
  logic        control_cs = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        tone_write;
  logic        tone_period_cs;
  logic        tone_duration_cs;
  logic [31:0] tone_data;
  logic        tone_busy = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  int stub_mode = 0;
  int busy_cnt  = 0;

  typedef struct {
    int          at_cyc;
    logic        per;
    logic        dur;
    logic [31:0] data;
  } wr_t;

  wr_t log_q[$];
  wr_t mon_e;

  always #5 clock = ~clock;

  tone_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .read             (read),
    .write            (write),
    .queue_cs         (queue_cs),
    .status_cs        (status_cs),
    .control_cs       (control_cs),
    .data_in          (data_in),
    .data_out         (data_out),
    .data_out_valid   (data_out_valid),
    .tone_write       (tone_write),
    .tone_period_cs   (tone_period_cs),
    .tone_duration_cs (tone_duration_cs),
    .tone_data        (tone_data),
    .tone_busy        (tone_busy)
  );

  // Write monitor: edge index plus strobe sanity.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (tone_write || tone_period_cs || tone_duration_cs) begin
      if ((tone_period_cs && tone_duration_cs) || !tone_write ||
          !(tone_period_cs || tone_duration_cs)) begin
        viol = viol + 1;
      end
      mon_e.at_cyc = cyc;
      mon_e.per    = tone_period_cs;
      mon_e.dur    = tone_duration_cs;
      mon_e.data   = tone_data;
      log_q.push_back(mon_e);
    end
  end

  // Tonegen stub.
  always @(posedge clock) begin
    if (reset) begin
      busy_cnt  <= 0;
      tone_busy <= 1'b0;
    end else if (stub_mode == 1 && tone_write && tone_duration_cs) begin
      busy_cnt  <= 16;
      tone_busy <= 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt  <= busy_cnt - 1;
      tone_busy <= (busy_cnt > 1);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    write = 1'b1; queue_cs = 1'b1; data_in = w;
    tick();
    write = 1'b0; queue_cs = 1'b0; data_in = '0;
    $display("push   data=0x%08h edge=%0d", w, cyc);
  endtask

  task automatic ctrl(input logic [31:0] w);
    write = 1'b1; control_cs = 1'b1; data_in = w;
    tick();
    write = 1'b0; control_cs = 1'b0; data_in = '0;
    $display("ctrl   data=0x%08h edge=%0d", w, cyc);
  endtask

  task automatic status(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    read = 1'b1; status_cs = 1'b1;
    #1;
    got = data_out;
    chk(tag, got, exp);
    chk({tag, "_valid"}, 32'(data_out_valid), 32'h1);
    tick();
    read = 1'b0; status_cs = 1'b0;
    $display("status %s data=0x%08h edge=%0d", tag, got, cyc);
  endtask

  task automatic chk_log(input string tag, input int idx, input int exp_cyc,
                         input logic exp_per, input logic [31:0] exp_data);
    total++;
    assert (idx < log_q.size())
    else begin
      bad++;
      $error("FAIL %s write missing: observed=%0d writes required>%0d", tag, log_q.size(), idx);
    end
    if (idx < log_q.size()) begin
      chk({tag, "_edge"}, 32'(log_q[idx].at_cyc), 32'(exp_cyc));
      chk({tag, "_per"},  32'(log_q[idx].per),    32'(exp_per));
      chk({tag, "_dur"},  32'(log_q[idx].dur),    32'(!exp_per));
      chk({tag, "_data"}, log_q[idx].data,        exp_data);
    end
  endtask

  initial begin
    int n;
    int lb;

    // Reset state
    tick();
    tick();
    chk("rst_tone_write", 32'(tone_write), 32'h0);
    chk("rst_period_cs", 32'(tone_period_cs), 32'h0);
    chk("rst_duration_cs", 32'(tone_duration_cs), 32'h0);
    chk("rst_tone_data", tone_data, 32'h0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_dout_valid", 32'(data_out_valid), 32'h0);
    reset = 1'b0;
    tick();
    status("rst_status", 32'h0000_0001);

    // Two notes with 16-cycle tones; check latency and the inter-note gap
    stub_mode = 1;
    lb = log_q.size();
    push(32'h0100_0010);
    n = cyc;
    push(32'h0200_0020);
    status("t1_wrp", 32'h0000_0204);
    status("t1_wrd", 32'h0000_0204);
    status("t1_popped", 32'h0000_0104);
    repeat (42) tick();
    chk("t1_nwrites", 32'(log_q.size() - lb), 32'd4);
    chk_log("t1_p1", lb + 0, n + 2, 1'b1, 32'h0000_0100);
    chk_log("t1_d1", lb + 1, n + 3, 1'b0, 32'h0000_0010);
    chk_log("t1_p2", lb + 2, n + 22, 1'b1, 32'h0000_0200);
    chk_log("t1_d2", lb + 3, n + 23, 1'b0, 32'h0000_0020);
    status("t1_final", 32'h0000_0001);

    // Paused fill, overflow with concurrent status read, flush
    lb = log_q.size();
    ctrl(32'h1);
    for (int i = 0; i < 8; i++) push(32'h0100_0010 + 32'(i));
    write = 1'b1; queue_cs = 1'b1; data_in = 32'h0900_0009;
    read = 1'b1; status_cs = 1'b1;
    #1;
    chk("t2_ovf_same_cycle", data_out, 32'h0000_0812);
    tick();
    write = 1'b0; queue_cs = 1'b0; data_in = '0; read = 1'b0; status_cs = 1'b0;
    $display("push+status overflow edge=%0d", cyc);
    status("t2_ovf_set", 32'h0000_081A);
    status("t2_ovf_cleared", 32'h0000_0812);
    chk("t2_no_writes", 32'(log_q.size() - lb), 32'd0);
    ctrl(32'h2);
    status("t2_flushed", 32'h0000_0001);
    repeat (5) tick();
    chk("t2_no_writes_after", 32'(log_q.size() - lb), 32'd0);

    // Zero-duration note is discarded, the next one dispatches
    lb = log_q.size();
    push(32'h0300_0000);
    n = cyc;
    push(32'h0400_0005);
    repeat (25) tick();
    chk("t3_nwrites", 32'(log_q.size() - lb), 32'd2);
    chk_log("t3_p", lb + 0, n + 3, 1'b1, 32'h0000_0400);
    chk_log("t3_d", lb + 1, n + 4, 1'b0, 32'h0000_0005);
    status("t3_final", 32'h0000_0001);

    // Silent tonegen: WAIT_START times out after 4 cycles
    stub_mode = 0;
    lb = log_q.size();
    push(32'h0500_0007);
    n = cyc;
    push(32'h0600_0008);
    repeat (5) tick();
    status("t4_wait_last", 32'h0000_0104);
    status("t4_idle", 32'h0000_0100);
    repeat (15) tick();
    chk("t4_nwrites", 32'(log_q.size() - lb), 32'd4);
    chk_log("t4_d1", lb + 1, n + 3, 1'b0, 32'h0000_0007);
    chk_log("t4_p2", lb + 2, n + 9, 1'b1, 32'h0000_0600);
    chk_log("t4_d2", lb + 3, n + 10, 1'b0, 32'h0000_0008);
    status("t4_final", 32'h0000_0001);

    // Mid-tone flush with 5 queued and a same-cycle push
    stub_mode = 1;
    lb = log_q.size();
    for (int i = 0; i < 6; i++) push(32'h0700_0009 + 32'(i << 16));
    status("t5_before", 32'h0000_0504);
    write = 1'b1; control_cs = 1'b1; queue_cs = 1'b1; data_in = 32'h0000_0002;
    tick();
    write = 1'b0; control_cs = 1'b0; queue_cs = 1'b0; data_in = '0;
    $display("flush+push edge=%0d", cyc);
    status("t5_after", 32'h0000_0005);
    repeat (20) tick();
    chk("t5_nwrites", 32'(log_q.size() - lb), 32'd2);
    status("t5_final", 32'h0000_0001);

    // Reset during WAIT_END with 3 queued
    lb = log_q.size();
    for (int i = 0; i < 4; i++) push(32'h0A00_000C + 32'(i << 16));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset pulse edge=%0d", cyc);
    chk("t6_tone_write", 32'(tone_write), 32'h0);
    chk("t6_period_cs", 32'(tone_period_cs), 32'h0);
    chk("t6_duration_cs", 32'(tone_duration_cs), 32'h0);
    chk("t6_tone_data", tone_data, 32'h0);
    chk("t6_data_out", data_out, 32'h0);
    chk("t6_dout_valid", 32'(data_out_valid), 32'h0);
    status("t6_status", 32'h0000_0001);
    repeat (30) tick();
    chk("t6_nwrites", 32'(log_q.size() - lb), 32'd2);

    chk("strobe_rules", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Queued note player between the CPU IO bus and `tonegen_interface`. The CPU pushes (period, duration) note words into an 8-entry FIFO through IO registers. The sequencer drives the tonegen's period and duration register writes itself, one note at a time, waiting for each tone to finish before dispatching the next. It owns the tonegen's register-side inputs, so in this configuration the CPU no longer writes the tonegen directly.

## Interface
Parameters:
- `DEPTH`, 8, FIFO entries; power of two, 2..256
- `PERIOD_WIDTH`, 16, period field width; the field occupies `data_in[31:16]`
- `DURATION_WIDTH`, 16, duration field width; the field occupies `data_in[15:0]`

Ports:
- `clock`  in  1  CPU clock; the block's only clock
- `reset`  in  1  synchronous, active-high reset
- `read`  in  1  CPU bus read strobe
- `write`  in  1  CPU bus write strobe
- `queue_cs`  in  1  select for the note queue register (write-only)
- `status_cs`  in  1  select for the status register (read-only)
- `control_cs`  in  1  select for the control register (write-only)
- `data_in`  in  32  CPU write data
- `data_out`  out  32  CPU read data
- `data_out_valid`  out  1  high when `data_out` should be muxed onto the CPU bus
- `tone_write`  out  1  write strobe to tonegen
- `tone_period_cs`  out  1  tonegen period register select
- `tone_duration_cs`  out  1  tonegen duration register select
- `tone_data`  out  32  write data to tonegen
- `tone_busy`  in  1  tonegen playing flag; high while a tone sounds

## Operation
Queue push:
- A write to `queue_cs` pushes `data_in` into the FIFO.
- If the FIFO is full, the word is dropped and sticky `overflow` is set.
- The full check uses the count before this cycle's edge. A push to a full FIFO is rejected even if a pop occurs in the same cycle.
- A push and a pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.

Status word (`data_out` on a status read):
- `[0]` empty
- `[1]` full
- `[2]` busy (FSM not IDLE, or `tone_busy`)
- `[3]` overflow
- `[4]` paused
- `[15:8]` count
- all other bits 0
- A status read clears `overflow` at that clock edge. If an overflowing push occurs in the same cycle, `overflow` stays set.

Control write:
- `[0]` sets `paused` (level; stays until rewritten).
- `[1]` is flush: clears the FIFO in that cycle. The tone in progress completes and flush does not abort it. If flush and a push occur in the same cycle, flush wins.

FSM states:
- IDLE:
  - If the FIFO is not empty and `paused` = 0 and `tone_busy` = 0, look at the head word.
  - Head duration = 0: pop it and stay in IDLE, with no tonegen write (the note is discarded).
  - Otherwise go to WR_PERIOD.
- WR_PERIOD: one cycle. `tone_write` = 1, `tone_period_cs` = 1, `tone_data` = zero-extended period. Go to WR_DURATION.
- WR_DURATION: one cycle. `tone_write` = 1, `tone_duration_cs` = 1, `tone_data` = zero-extended duration. Pop the head. Go to WAIT_START with the timeout counter = 0.
- WAIT_START: on `tone_busy` = 1 go to WAIT_END. If `tone_busy` stays low for 4 cycles, go to IDLE (timeout).
- WAIT_END: on `tone_busy` = 0 go to IDLE.

Other rules:
- Pausing never interrupts WR_PERIOD, WR_DURATION or the waits; it only blocks dispatch from IDLE.
- The head word is latched at IDLE→WR_PERIOD. A flush during WR_PERIOD still writes the latched duration and performs no pop on an empty FIFO.

## Timing
Reset values:
- All outputs 0; FIFO empty; pointers 0; `overflow` = 0; `paused` = 0; FSM in IDLE.
- A reset mid-note abandons the sequence with no further tonegen writes.

Bus side:
- `data_out_valid` = `read & status_cs`, combinational.
- `data_out` is combinational from registers and is 0 when `data_out_valid` = 0.
- Queue and control writes take effect at the edge of the strobe cycle.

Dispatch latency:
- FIFO becomes non-empty at edge N (IDLE, not paused, tone idle).
- Period write during cycle N+1; duration write during cycle N+2.
- Count decrements at edge N+3.
- Minimum inter-note gap after `tone_busy` falls: WAIT_END→IDLE on one edge, then 2 write cycles.

Tonegen strobes:
- Each `tone_write` pulse is exactly one cycle.
- `tone_period_cs` and `tone_duration_cs` are never high together, and are never high without `tone_write`.

## Test plan
- Push `0x0100_0010`, `0x0200_0020`, with a stub holding `tone_busy` high for 16 cycles after each duration write → tonegen sees writes 0x100, 0x10, then 0x200, 0x20 in order. The second period write occurs exactly 2 cycles after `tone_busy` falls. Final status reads `0x0000_0001`.
- Push 9 words while paused → 9th dropped. Status = `0x0000_081A` (count 8, full, overflow, paused). A second status read shows `[3]` = 0.
- Push `0x0300_0000`, then `0x0400_0005` → the first word is discarded with no tonegen writes, and the second is dispatched normally.
- Stub never raises `tone_busy` → after the duration write, the FSM returns to IDLE 4 cycles later and dispatches the next queued note.
- Mid-tone, write control = 2 with 5 notes queued → count goes to 0 at that edge. The current tone ends and no further writes occur. A push in the same cycle is also discarded.
- Assert `reset` for 1 cycle during WAIT_END with 3 notes queued → all outputs 0, status = `0x0000_0001`, and no tonegen strobes afterward.
